bank_register_vector: RTL and testbench
=======================================

// Module: bank_register_vector
// PURPOSE
//  Parametrised vector register bank: DEPTH registers, each LANES elements of WIDTH bits.
//  Two combinational read ports (A1/RD1, A2/RD2) and one lane-masked write port (A3/WD3/MASK3).
//  Post-reset hardware clear sequencer zeroes every entry before READY is raised.
//  Sits in the vector datapath beside the scalar bank; decode drives addresses and writeback drives WD3.
// PARAMETERS
//  WIDTH   32  element width in bits
//  LANES   4   elements per vector register
//  DEPTH   16  number of vector registers (>=2)
//  ADDR_W  $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  CLK    in   1             clock; all state updates on rising edge
//  RST    in   1             reset, synchronous and active-high
//  WE3    in   1             write enable, port 3
//  MASK3  in   LANES         per-lane write enable; bit i gates lane i
//  A1     in   ADDR_W        read address, port 1
//  A2     in   ADDR_W        read address, port 2
//  A3     in   ADDR_W        write address, port 3
//  WD3    in   LANES*WIDTH   write data; lane i = WD3[i*WIDTH +: WIDTH]
//  RD1    out  LANES*WIDTH   read data, port 1
//  RD2    out  LANES*WIDTH   read data, port 2
//  READY  out  1             1 = clear finished, bank accepts writes
// BEHAVIOUR
//  - FSM states: CLEAR, RUN. RST=1 at an edge -> CLEAR, clr_ptr=0, READY=0 (RST dominates all).
//  - CLEAR: each edge writes 0 to all lanes of entry clr_ptr and increments clr_ptr;
//    at clr_ptr==DEPTH-1 the last entry is zeroed and the state moves to RUN. Takes exactly DEPTH cycles.
//  - READY is registered: 0 in CLEAR, 1 in RUN. First accepted write is on the edge after READY=1.
//  - RST asserted mid-CLEAR restarts from clr_ptr=0; RST in RUN re-enters CLEAR (contents re-zeroed).
//  - In CLEAR: WE3 ignored (write dropped, not queued); RD1/RD2 forced to 0.
//  - RUN write: at edge, if WE3 then for each lane i with MASK3[i]=1, entry[A3].lane[i] <= WD3 lane i;
//    unmasked lanes hold. WE3=1 with MASK3=0 is a no-op.
//  - Reads asynchronous: RD1=entry[A1], RD2=entry[A2]; A1==A2 legal, both ports return the same value.
//  - Without forwarding, a read of A3 in the write cycle returns the old value (write visible next cycle).
//  - No arithmetic; addresses >= DEPTH (non-power-of-2 DEPTH): write dropped, read returns 0.
// CONFIGURATION
//  - VREG_FORWARD_EN defined: in RUN, if WE3 and A1==A3, RD1 lane i = WD3 lane i for every i with
//    MASK3[i]=1, other lanes from storage; same rule for A2/RD2. Combinational, same cycle.
//  - Not defined: no bypass; read-during-write returns pre-write contents. No bypass in CLEAR either way.
// STRUCTURE
//  - Package vreg_pkg: typedef enum logic {CLEAR, RUN} vreg_state_t; lane/vector typedefs
//    parameterised via localparams VREG_WIDTH=32, VREG_LANES=4, VREG_DEPTH=16 defaults.
//  - Sub-module vreg_lane: DEPTH x WIDTH storage for one lane, 1 write + 2 async reads,
//    generated LANES times; top holds FSM, clr_ptr, mask fan-out, forwarding muxes.
// TESTING
//  1 Reset/clear: preload entry 5 = all 0xFFFFFFFF, pulse RST 1 cycle -> READY=0 for 16 cycles,
//    then 1; RD1 with A1=5 reads 0; writes attempted during CLEAR leave entries 0.
//  2 Masked write: WE3=1, A3=8, MASK3=4'b0101, WD3={4{32'hFFFC0007}} over zeroed entry ->
//    next cycle RD1(A1=8) = {32'h0,32'hFFFC0007,32'h0,32'hFFFC0007}.
//  3 Dual read: entry1={4{32'hF0000007}}, entry4={4{32'hF00FF007}}; A1=1,A2=4 -> both values;
//    A1=A2=4 -> both ports 32'hF00FF007 per lane.
//  4 Read-during-write A3=A1=3, MASK3=4'b1111, WD3={4{32'hAAAAAAAA}} over zero: forwarding off ->
//    RD1=0 that cycle, AAAA.. next; VREG_FORWARD_EN -> RD1=AAAA.. same cycle; repeat MASK3=4'b0011.
//  5 RST mid-clear at cycle 7 -> clear restarts, READY rises exactly 16 cycles after RST release edge.
//  6 WE3=0 with valid A3/WD3, and WE3=1 with MASK3=0 -> no entry changes (full readback of all 16).

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared types and default geometry for the vector register bank.
package vreg_pkg;
  localparam int unsigned VREG_WIDTH = 32;
  localparam int unsigned VREG_LANES = 4;
  localparam int unsigned VREG_DEPTH = 16;

  typedef enum logic {CLEAR, RUN} vreg_state_t;
  typedef logic [VREG_WIDTH-1:0] vreg_elem_t;
  typedef vreg_elem_t [VREG_LANES-1:0] vreg_vec_t;
endpackage

// File: rtl/vreg_lane.sv
// One lane of the vector bank: DEPTH x WIDTH storage, one write port, two async reads.
module vreg_lane
  import vreg_pkg::*;
#(
  parameter int unsigned WIDTH  = VREG_WIDTH,
  parameter int unsigned DEPTH  = VREG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [WIDTH-1:0]  wd_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  // Raw reads; range checking and clear-time gating live in the top.
  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
endmodule

// File: rtl/bank_register_vector.sv
// Vector register bank with post-reset clear sequencer and lane-masked writes.
// Optional same-cycle write-to-read bypass when VREG_FORWARD_EN is defined.
module bank_register_vector
  import vreg_pkg::*;
#(
  parameter int unsigned WIDTH  = VREG_WIDTH,
  parameter int unsigned LANES  = VREG_LANES,
  parameter int unsigned DEPTH  = VREG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WE3,
  input  logic [LANES-1:0]       MASK3,
  input  logic [ADDR_W-1:0]      A1,
  input  logic [ADDR_W-1:0]      A2,
  input  logic [ADDR_W-1:0]      A3,
  input  logic [LANES*WIDTH-1:0] WD3,
  output logic [LANES*WIDTH-1:0] RD1,
  output logic [LANES*WIDTH-1:0] RD2,
  output logic                   READY
);
  vreg_state_t       state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              clearing;
  logic              a1_ok, a2_ok, a3_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN: ;
    endcase
    ready_d = (state_d == RUN);
  end

  assign clearing = (state_q == CLEAR);
  assign READY    = ready_q;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  if (DEPTH == (32'd1 << ADDR_W)) begin : g_pow2
    assign a1_ok = 1'b1;
    assign a2_ok = 1'b1;
    assign a3_ok = 1'b1;
  end else begin : g_npow2
    assign a1_ok = ({1'b0, A1} < (ADDR_W+1)'(DEPTH));
    assign a2_ok = ({1'b0, A2} < (ADDR_W+1)'(DEPTH));
    assign a3_ok = ({1'b0, A3} < (ADDR_W+1)'(DEPTH));
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd, rd1, rd2, o1, o2;

    assign we = !RST && (clearing || (WE3 && MASK3[i] && a3_ok));
    assign wa = clearing ? clr_ptr_q : A3;
    assign wd = clearing ? '0 : WD3[i*WIDTH +: WIDTH];

    vreg_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
      .clk_i (CLK),
      .we_i  (we),
      .wa_i  (wa),
      .wd_i  (wd),
      .ra1_i (A1),
      .ra2_i (A2),
      .rd1_o (rd1),
      .rd2_o (rd2)
    );

`ifdef VREG_FORWARD_EN
    logic fwd1, fwd2;
    assign fwd1 = !clearing && WE3 && MASK3[i] && a3_ok && (A1 == A3);
    assign fwd2 = !clearing && WE3 && MASK3[i] && a3_ok && (A2 == A3);
    assign o1 = fwd1 ? WD3[i*WIDTH +: WIDTH] : rd1;
    assign o2 = fwd2 ? WD3[i*WIDTH +: WIDTH] : rd2;
`else
    assign o1 = rd1;
    assign o2 = rd2;
`endif

    assign RD1[i*WIDTH +: WIDTH] = (clearing || !a1_ok) ? '0 : o1;
    assign RD2[i*WIDTH +: WIDTH] = (clearing || !a2_ok) ? '0 : o2;
  end
endmodule

// File: tb/tb_bank_register_vector.sv
// Scoreboard bench for bank_register_vector; honours VREG_FORWARD_EN in its model.
module tb_bank_register_vector;
  localparam int unsigned W  = 32;
  localparam int unsigned L  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned VW = L * W;

  logic          CLK = 1'b0;
  logic          RST, WE3, READY;
  logic [L-1:0]  MASK3;
  logic [AW-1:0] A1, A2, A3;
  logic [VW-1:0] WD3, RD1, RD2;

  always #5 CLK = ~CLK;

  bank_register_vector #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .WE3(WE3), .MASK3(MASK3),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .READY(READY)
  );

  typedef struct packed {
    logic [VW-1:0] rd1;
    logic [VW-1:0] rd2;
    logic          rdy;
  } exp_t;

  exp_t          sb[$];
  logic [VW-1:0] mdl [D];
  bit            m_ready;
  int unsigned   m_cnt;
  int unsigned   vectors, miscompares;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    v = m_ready ? mdl[a] : '0;
`ifdef VREG_FORWARD_EN
    if (m_ready && WE3 && a == A3)
      for (int i = 0; i < L; i++)
        if (MASK3[i]) v[i*W +: W] = WD3[i*W +: W];
`endif
    return v;
  endfunction

  // One clock: predict, sample at negedge, then advance the model on the edge.
  task automatic cycle(input string tag);
    exp_t e;
    e.rd1 = exp_rd(A1);
    e.rd2 = exp_rd(A2);
    e.rdy = m_ready;
    sb.push_back(e);
    @(negedge CLK);
    e = sb.pop_front();
    chk({tag, ".rd1"}, RD1, e.rd1);
    chk({tag, ".rd2"}, RD2, e.rd2);
    chk({tag, ".rdy"}, VW'(READY), VW'(e.rdy));
    @(posedge CLK);
    if (RST) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      mdl[m_cnt] = '0;
      if (m_cnt == D - 1) m_ready = 1'b1;
      m_cnt++;
    end else if (WE3) begin
      for (int i = 0; i < L; i++)
        if (MASK3[i]) mdl[A3][i*W +: W] = WD3[i*W +: W];
    end
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (READY !== 1'b1 && n < 40) begin
      cycle(tag);
      n++;
    end
    chk({tag, ".lat"}, VW'(n), VW'(16));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [L-1:0] m, input logic [VW-1:0] d);
    WE3 = 1'b1; A3 = a; MASK3 = m; WD3 = d; A1 = a; A2 = a;
    cycle("wr");
    WE3 = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] exp_v;
    vectors = 0; miscompares = 0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    m_ready = 1'b0; m_cnt = 0;
    RST = 1'b1; WE3 = 1'b0; MASK3 = '0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("por.rdy", VW'(READY), VW'(0));
    wait_ready("por");

    // Reset/clear: preloaded entry re-zeroed, writes during clear dropped
    wr(4'd5, 4'hF, {4{32'hFFFFFFFF}});
    A1 = 4'd5;
    cycle("pre");
    chk("pre.val", RD1, {4{32'hFFFFFFFF}});
    RST = 1'b1;
    cycle("rst1");
    RST = 1'b0;
    WE3 = 1'b1; A3 = 4'd5; MASK3 = 4'hF; WD3 = {4{32'h12345678}};
    wait_ready("clr1");
    WE3 = 1'b0; A1 = 4'd5; A2 = 4'd0;
    cycle("clr1.rd");
    chk("clr1.e5", RD1, '0);

    // Masked write
    wr(4'd8, 4'b0101, {4{32'hFFFC0007}});
    A1 = 4'd8;
    cycle("mask");
    chk("mask.val", RD1, {32'h0, 32'hFFFC0007, 32'h0, 32'hFFFC0007});

    // Dual read, including A1 == A2
    wr(4'd1, 4'hF, {4{32'hF0000007}});
    wr(4'd4, 4'hF, {4{32'hF00FF007}});
    A1 = 4'd1; A2 = 4'd4;
    cycle("dual");
    chk("dual.a", RD1, {4{32'hF0000007}});
    chk("dual.b", RD2, {4{32'hF00FF007}});
    A1 = 4'd4;
    cycle("same");

    // Read-during-write
    WE3 = 1'b1; A3 = 4'd3; A1 = 4'd3; A2 = 4'd0; MASK3 = 4'hF; WD3 = {4{32'hAAAAAAAA}};
`ifdef VREG_FORWARD_EN
    exp_v = {4{32'hAAAAAAAA}};
`else
    exp_v = '0;
`endif
    #1 chk("rdw.same", RD1, exp_v);
    cycle("rdw1");
    WE3 = 1'b0;
    cycle("rdw1.n");
    chk("rdw1.next", RD1, {4{32'hAAAAAAAA}});
    WE3 = 1'b1; MASK3 = 4'b0011; WD3 = {4{32'h55555555}};
    cycle("rdw2");
    WE3 = 1'b0;
    cycle("rdw2.n");
    chk("rdw2.next", RD1, {{2{32'hAAAAAAAA}}, {2{32'h55555555}}});

    // Reset mid-clear restarts the sequence
    RST = 1'b1;
    cycle("rst2");
    RST = 1'b0;
    for (int i = 0; i < 7; i++) cycle("clr2");
    RST = 1'b1;
    cycle("rst3");
    RST = 1'b0;
    wait_ready("clr3");

    // No-op writes leave every entry untouched
    for (int i = 0; i < D; i++)
      wr(AW'(i), 4'hF, {4{$urandom()}});
    WE3 = 1'b0; A3 = 4'd2; MASK3 = 4'hF; WD3 = {4{32'hDEADBEEF}};
    cycle("we0");
    WE3 = 1'b1; MASK3 = 4'h0;
    cycle("m0");
    WE3 = 1'b0;
    for (int i = 0; i < D; i++) begin
      A1 = AW'(i); A2 = AW'(D - 1 - i);
      cycle("rb");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
